ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, frames 11-bit
// packets, and tracks the held state of the four extended arrow keys.
module ps2_key_decoder #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_error,
  output logic [3:0] keys
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    scan_q, scan_d;
  logic          cv_q, cv_d, fe_q, fe_d;
  logic [3:0]    keys_q, keys_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          fall;

  always_comb begin
    clk_meta_d  = ps2_clk;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data;
    data_sync_d = data_meta_q;
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_cnt_d    = to_cnt_q;
    scan_d      = scan_q;
    cv_d        = 1'b0;
    fe_d        = 1'b0;
    keys_d      = keys_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    fall        = 1'b0;

    // Level flips only on the FILTER-th consecutive sample that disagrees with it.
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FILT_MAX) begin
        filt_d = clk_sync_q;
        fall   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (fall && !data_sync_q) begin
          state_d   = RECV;
          bit_cnt_d = 4'd1;
          to_cnt_d  = '0;
        end
      end
      RECV: begin
        if (fall) begin
          shift_d   = {data_sync_q, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 4'd10) state_d = CHECK;
        end else if (to_cnt_q == TO_MAX) begin
          state_d  = IDLE;
          to_cnt_d = '0;
          fe_d     = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        if ((^shift_q[8:0]) && shift_q[9]) begin
          scan_d = shift_q[7:0];
          cv_d   = 1'b1;
        end else begin
          fe_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Key tracking runs one cycle behind the registered code_valid pulse.
    if (cv_q) begin
      if (scan_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (scan_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q) begin
          case (scan_q)
            8'h75:   keys_d[0] = ~brk_q;
            8'h72:   keys_d[1] = ~brk_q;
            8'h6B:   keys_d[2] = ~brk_q;
            8'h74:   keys_d[3] = ~brk_q;
            default: keys_d = keys_q;
          endcase
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end else if (fe_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      scan_q      <= 8'h00;
      cv_q        <= 1'b0;
      fe_q        <= 1'b0;
      keys_q      <= 4'b0000;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      scan_q      <= scan_d;
      cv_q        <= cv_d;
      fe_q        <= fe_d;
      keys_q      <= keys_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
    end
  end

  assign scan_code   = scan_q;
  assign code_valid  = cv_q;
  assign frame_error = fe_q;
  assign keys        = keys_q;

endmodule
